// File: rtl/or16_accumulator_if.sv
// Valid/ready bus for the OR-accumulator stage: upstream words in, folded frame results out.
// The master side is the word producer / result consumer; the slave side is the accumulator.
interface or16_accumulator_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_nonzero;
  logic [CNT_W-1:0] out_words;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_nonzero, out_words
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_nonzero, out_words
  );
endinterface

// File: rtl/or16_accumulator.sv
// Sticky OR accumulator: folds up to COUNT words into one result word, closed early by flush,
// presented over a valid/ready handshake together with a nonzero flag and the word count.
module or16_accumulator #(
  parameter int WIDTH = 16,
  parameter int COUNT = 4,
  parameter int CNT_W = 4
) (
  input logic                clk,
  input logic                rst_n,
  input logic                clear,
  input logic                flush,
  or16_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_nonzero_q;
  logic [CNT_W-1:0] out_words_q;

  logic             accept;
  logic             close;
  logic [WIDTH-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  assign bus.in_ready    = (state != DONE);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_nonzero = out_nonzero_q;
  assign bus.out_words   = out_words_q;

  // acc_nxt/cnt_nxt already include a same-cycle word, so a closing frame captures it.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    accept  = bus.in_valid && (state != DONE);
    acc_nxt = acc;
    cnt_nxt = cnt;
    if (accept) begin
      if (state == IDLE) begin
        acc_nxt = bus.in_data;
        cnt_nxt = CNT_W'(1);
      end else begin
        acc_nxt = acc | bus.in_data;
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
    close = (accept && (cnt_nxt == CNT_W'(COUNT))) || (flush && (accept || state == ACC));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_nonzero_q <= 1'b0;
      out_words_q   <= '0;
    end else if (clear) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_nonzero_q <= 1'b0;
      out_words_q   <= '0;
    end else if (state == DONE) begin
      // Result stays frozen until the consumer takes it.
      if (bus.out_ready) begin
        state       <= IDLE;
        acc         <= '0;
        cnt         <= '0;
        out_valid_q <= 1'b0;
      end
    end else begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      if (close) begin
        state         <= DONE;
        out_data_q    <= acc_nxt;
        out_words_q   <= cnt_nxt;
        out_nonzero_q <= |acc_nxt;
        out_valid_q   <= 1'b1;
      end else if (accept) begin
        state <= ACC;
      end
    end
  end

endmodule

// File: tb/tb_or16_accumulator.sv
// Scoreboard bench for or16_accumulator: the driver closes frames in a word-list model and
// queues expected results; a negedge monitor pops and compares whenever out_valid appears.
module tb_or16_accumulator;

  localparam int WIDTH = 16;
  localparam int COUNT = 4;
  localparam int CNT_W = 4;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               words;
    longint           due;
  } exp_t;

  logic clk;
  logic rst_n;
  logic clear;
  logic flush;

  or16_accumulator_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  or16_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .flush (flush),
    .bus   (bus)
  );

  int               n_compared  = 0;
  int               n_mismatch  = 0;
  longint           cyc         = 0;
  logic [WIDTH-1:0] frame[$];
  exp_t             exp_q[$];
  exp_t             cur;
  bit               holding     = 0;
  bit               release_chk = 0;
  bit               rand_ready  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is the list of words since the last close; its result is their OR.
  task automatic close_frame(input longint due);
    exp_t e;
    e.data = '0;
    foreach (frame[i]) e.data = e.data | frame[i];
    e.words = frame.size();
    e.due   = due;
    exp_q.push_back(e);
    frame.delete();
  endtask

  task automatic model_drop();
    frame.delete();
    exp_q.delete();
    holding     = 0;
    release_chk = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the word was accepted.
  task automatic send_word(input logic [WIDTH-1:0] d, input bit fl);
    int     n = 0;
    longint due;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    flush        = fl;
    @(negedge clk);
    while (!bus.in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    due = cyc + 1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    frame.push_back(d);
    if (frame.size() == COUNT || fl) close_frame(due);
  endtask

  task automatic flush_only();
    longint due;
    flush = 1'b1;
    @(negedge clk);
    due = cyc + 1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    if (frame.size() > 0) close_frame(due);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || holding) && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_pending", 32'(exp_q.size()) + 32'(holding), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
    check({tag, "_out_nonzero"}, 32'(bus.out_nonzero), 32'd0);
    check({tag, "_out_words"}, 32'(bus.out_words), 32'd0);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (release_chk) begin
        check("release_out_valid", 32'(bus.out_valid), 32'd0);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
        release_chk = 0;
      end
      if (bus.out_valid) begin
        check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
        if (!holding) begin
          if (exp_q.size() == 0) begin
            check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
          end else begin
            cur = exp_q.pop_front();
            check("out_data", 32'(bus.out_data), 32'(cur.data));
            check("out_words", 32'(bus.out_words), 32'(cur.words));
            check("out_nonzero", 32'(bus.out_nonzero), 32'(cur.data != 0));
            check("latency_cycle", 32'(cyc), 32'(cur.due));
            holding = 1;
          end
        end else begin
          check("held_out_data", 32'(bus.out_data), 32'(cur.data));
          check("held_out_words", 32'(bus.out_words), 32'(cur.words));
        end
        if (bus.out_ready) begin
          holding     = 0;
          release_chk = 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    rst_n         = 1'b0;
    clear         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #3;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);

    // Full frame, back-to-back, out_ready=1
    @(posedge clk);
    #1;
    send_word(16'h0001, 0);
    send_word(16'h0010, 0);
    send_word(16'h0100, 0);
    send_word(16'h1000, 0);
    wait_drain();

    // Backpressure
    bus.out_ready = 1'b0;
    send_word(16'h0001, 0);
    send_word(16'h0010, 0);
    send_word(16'h0100, 0);
    send_word(16'h1000, 0);
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain();

    // Zero frame
    repeat (4) send_word(16'h0000, 0);
    wait_drain();

    // Flush with same-cycle accept, then flush in IDLE
    send_word(16'hA000, 0);
    send_word(16'h000A, 1);
    wait_drain();
    @(posedge clk);
    #1;
    flush_only();
    repeat (3) begin
      @(negedge clk);
      check("idle_flush_out_valid", 32'(bus.out_valid), 32'd0);
      check("idle_flush_in_ready", 32'(bus.in_ready), 32'd1);
    end
    @(posedge clk);
    #1;

    // Clear beats a same-cycle accept
    repeat (3) send_word(16'h0F00, 0);
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hFFFF;
    @(posedge clk);
    #1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    model_drop();
    @(negedge clk);
    check("clear_out_valid", 32'(bus.out_valid), 32'd0);
    check("clear_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    repeat (4) send_word(16'h0003, 0);
    wait_drain();

    // Async reset mid-frame
    send_word(16'h1234, 0);
    send_word(16'h4321, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_drop();
    check_zero("rst_midframe");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);

    // Async reset while in DONE
    bus.out_ready = 1'b0;
    repeat (4) send_word(16'h8001, 0);
    repeat (2) @(negedge clk);
    check("pre_rst_done_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_drop();
    check_zero("rst_done");
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("rst_done_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    send_word(16'h0001, 0);
    send_word(16'h0010, 0);
    send_word(16'h0100, 0);
    send_word(16'h1000, 0);
    wait_drain();

    // Randomised traffic: sparse data, random flushes, gaps and consumer stalls
    rand_ready = 1;
    for (int i = 0; i < 150; i++) begin
      logic [WIDTH-1:0] d;
      d = ($urandom_range(0, 3) == 0) ? 16'h0000 : (16'($urandom) & 16'($urandom));
      send_word(d, $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 11) == 0) flush_only();
    end
    flush_only();
    rand_ready = 0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    wait_drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
